// File: rtl/xosera_bus_pkg.sv
// Shared types and default timing for the Xosera register-bus master.
package xosera_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } bus_state_e;

  localparam int DEF_SETUP_CYCLES  = 1;
  localparam int DEF_STROBE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES   = 2;

  localparam logic BYTESEL_HI = 1'b0;
  localparam logic BYTESEL_LO = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/xosera_bus_master.sv
// Xosera 8-bit register-bus master: serialises 16-bit commands into timed byte cycles.
// Define XOSERA_BUS_READ_EN to enable bus reads; otherwise reads complete at once with zero data.
module xosera_bus_master
  import xosera_bus_pkg::*;
#(
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rd,
  input  logic        cmd_lo_only,
  input  logic [3:0]  cmd_reg,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic        xosera_cs_n,
  output logic        xosera_rd_nwr,
  output logic [3:0]  xosera_reg_num,
  output logic        xosera_bytesel,
  output logic [7:0]  xosera_data_out,
  input  logic [7:0]  xosera_data_in
);

  localparam int MAX_CYCLES = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);

  if (SETUP_CYCLES < 1) begin : g_bad_setup
    $error("xosera_bus_master: SETUP_CYCLES must be >= 1");
  end
  if (STROBE_CYCLES < 2) begin : g_bad_strobe
    $error("xosera_bus_master: STROBE_CYCLES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("xosera_bus_master: HOLD_CYCLES must be >= 1");
  end

  bus_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [15:0]      rsp_data_q, rsp_data_d;
  logic             cs_n_q, cs_n_d;
  logic [3:0]       reg_num_q, reg_num_d;
  logic             bytesel_q, bytesel_d;
  logic [7:0]       data_out_q, data_out_d;
  logic [7:0]       data_lo_q, data_lo_d;
  logic             accept_s;
  logic             start_s;

  assign accept_s = cmd_valid && cmd_ready_q;

`ifdef XOSERA_BUS_READ_EN
  logic        rd_q, rd_d;
  logic        rd_nwr_q, rd_nwr_d;
  logic [15:0] rd_buf_q, rd_buf_d;

  assign start_s       = accept_s;
  assign xosera_rd_nwr = rd_nwr_q;
`else
  logic null_rd_s;
  logic unused_data_in_s;

  // Reads never reach the bus in this build; they are answered locally.
  assign start_s          = accept_s && !cmd_rd;
  assign null_rd_s        = accept_s && cmd_rd;
  assign unused_data_in_s = ^xosera_data_in;
  assign xosera_rd_nwr    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reg_num_d   = reg_num_q;
    bytesel_d   = bytesel_q;
    data_out_d  = data_out_q;
    data_lo_d   = data_lo_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
`ifdef XOSERA_BUS_READ_EN
    rd_d        = rd_q;
    rd_nwr_d    = rd_nwr_q;
    rd_buf_d    = rd_buf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d    = SETUP;
          cnt_d      = SETUP_LD;
          reg_num_d  = cmd_reg;
          data_lo_d  = cmd_data[7:0];
          bytesel_d  = cmd_lo_only ? BYTESEL_LO : BYTESEL_HI;
          data_out_d = cmd_lo_only ? cmd_data[7:0] : cmd_data[15:8];
`ifdef XOSERA_BUS_READ_EN
          rd_d       = cmd_rd;
          rd_nwr_d   = cmd_rd;
          rd_buf_d   = 16'h0000;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      STROBE: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
`ifdef XOSERA_BUS_READ_EN
          // Data is captured on the last strobe cycle, into the byte being transferred.
          if (rd_q && (bytesel_q == BYTESEL_HI)) begin
            rd_buf_d[15:8] = xosera_data_in;
          end else if (rd_q) begin
            rd_buf_d[7:0] = xosera_data_in;
          end else begin
            rd_buf_d = rd_buf_q;
          end
`endif
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (bytesel_q == BYTESEL_HI) begin
          state_d    = SETUP;
          cnt_d      = SETUP_LD;
          bytesel_d  = BYTESEL_LO;
          data_out_d = data_lo_q;
        end else begin
          state_d = IDLE;
`ifdef XOSERA_BUS_READ_EN
          rd_nwr_d = 1'b1;
          if (rd_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_buf_q;
          end else begin
            rsp_valid_d = 1'b0;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifndef XOSERA_BUS_READ_EN
    if (null_rd_s) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = 16'h0000;
    end else begin
      rsp_valid_d = 1'b0;
    end
`endif
    cs_n_d      = (state_d != STROBE);
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      cs_n_q      <= 1'b1;
      reg_num_q   <= 4'h0;
      bytesel_q   <= BYTESEL_HI;
      data_out_q  <= 8'h00;
      data_lo_q   <= 8'h00;
`ifdef XOSERA_BUS_READ_EN
      rd_q        <= 1'b0;
      rd_nwr_q    <= 1'b1;
      rd_buf_q    <= 16'h0000;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cs_n_q      <= cs_n_d;
      reg_num_q   <= reg_num_d;
      bytesel_q   <= bytesel_d;
      data_out_q  <= data_out_d;
      data_lo_q   <= data_lo_d;
`ifdef XOSERA_BUS_READ_EN
      rd_q        <= rd_d;
      rd_nwr_q    <= rd_nwr_d;
      rd_buf_q    <= rd_buf_d;
`endif
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign busy            = busy_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign xosera_cs_n     = cs_n_q;
  assign xosera_reg_num  = reg_num_q;
  assign xosera_bytesel  = bytesel_q;
  assign xosera_data_out = data_out_q;

endmodule

// File: tb/tb_xosera_bus_master.sv
// Randomised self-checking bench for xosera_bus_master; bus activity is logged and compared
// against byte-cycle timing derived from the setup/strobe/hold parameters.
module tb_xosera_bus_master;

  localparam int S = 1;
  localparam int T = 4;
  localparam int H = 2;
  localparam int B = S + T + H;
`ifdef XOSERA_BUS_READ_EN
  localparam logic IDLE_RNW = 1'b1;
`else
  localparam logic IDLE_RNW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_rd, cmd_lo_only;
  logic [3:0]  cmd_reg;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        busy, xosera_cs_n, xosera_rd_nwr, xosera_bytesel;
  logic [3:0]  xosera_reg_num;
  logic [7:0]  xosera_data_out, xosera_data_in;
  logic [7:0]  rd_hi_v, rd_lo_v;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // Simple Xosera register model: presents a different byte for each half of the word.
  assign xosera_data_in = (xosera_bytesel == 1'b0) ? rd_hi_v : rd_lo_v;

  xosera_bus_master #(.SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_lo_only(cmd_lo_only),
    .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .xosera_cs_n(xosera_cs_n), .xosera_rd_nwr(xosera_rd_nwr), .xosera_reg_num(xosera_reg_num),
    .xosera_bytesel(xosera_bytesel), .xosera_data_out(xosera_data_out),
    .xosera_data_in(xosera_data_in)
  );

  typedef struct {
    int         start;
    int         len;
    logic       bs;
    logic [7:0] data;
    logic [3:0] rnum;
    logic       rnw;
    bit         stable;
  } strb_t;

  strb_t       strb_q[$];
  int          rsp_cyc_q[$];
  logic [15:0] rsp_dat_q[$];
  int          cyc = 0;

  // Bus monitor: one entry per cs_n-low interval, plus a log of response pulses.
  initial begin
    strb_t cur;
    bit    in_s;
    in_s = 1'b0;
    cur  = '{default: 0};
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (xosera_cs_n === 1'b0) begin
        if (!in_s) begin
          cur.start = cyc; cur.len = 1; cur.bs = xosera_bytesel; cur.data = xosera_data_out;
          cur.rnum = xosera_reg_num; cur.rnw = xosera_rd_nwr; cur.stable = 1'b1;
          in_s = 1'b1;
        end else begin
          cur.len++;
          if (cur.bs !== xosera_bytesel || cur.data !== xosera_data_out ||
              cur.rnum !== xosera_reg_num || cur.rnw !== xosera_rd_nwr) cur.stable = 1'b0;
        end
      end else if (in_s) begin
        strb_q.push_back(cur);
        in_s = 1'b0;
      end
      if (rsp_valid === 1'b1) begin
        rsp_cyc_q.push_back(cyc);
        rsp_dat_q.push_back(rsp_data);
      end
    end
  end

  task automatic clear_logs();
    strb_q.delete();
    rsp_cyc_q.delete();
    rsp_dat_q.delete();
  endtask

  // Offer one command, return its accept cycle and the accept-to-ready latency (-1 on timeout).
  task automatic do_cmd(input logic rd, input logic lo, input logic [3:0] r, input logic [15:0] d,
                        output int acc, output int lat);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    cmd_rd = rd; cmd_lo_only = lo; cmd_reg = r; cmd_data = d; cmd_valid = 1'b1;
    @(negedge clk);
    acc = cyc - 1;
    cmd_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 80; k++) begin
      if (cmd_ready === 1'b1) begin
        lat = cyc - acc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_lo_only = 1'b0; cmd_reg = 4'h0; cmd_data = 16'h0000;
    rd_hi_v = 8'h00; rd_lo_v = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, busy, rsp_valid, rsp_data, xosera_cs_n, xosera_rd_nwr, xosera_reg_num,
         xosera_bytesel, xosera_data_out} !== {1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, IDLE_RNW, 4'h0, 1'b0, 8'h00})
      $display("FAIL reset_values: got rdy=%b busy=%b rv=%b rd=%h cs=%b rnw=%b reg=%h bs=%b do=%h",
               cmd_ready, busy, rsp_valid, rsp_data, xosera_cs_n, xosera_rd_nwr, xosera_reg_num,
               xosera_bytesel, xosera_data_out);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write(input logic lo, input int npat);
    logic [3:0]  r;
    logic [15:0] d;
    logic        ebs;
    logic [7:0]  ed;
    int acc, lat, nb;
    nb = lo ? 1 : 2;
    for (int p = 0; p < npat; p++) begin
      r = (p == 0) ? (lo ? 4'h1 : 4'h3) : 4'($urandom_range(15));
      d = (p == 0) ? (lo ? 16'hFF77 : 16'hA55A) : 16'($urandom);
      clear_logs();
      do_cmd(1'b0, lo, r, d, acc, lat);
      @(negedge clk);
      checks++;
      if (lat != nb * B + 1) $display("FAIL wr_latency lo=%b: got %0d expected %0d", lo, lat, nb * B + 1);
      else passed++;
      checks++;
      if (strb_q.size() != nb) $display("FAIL wr_strobe_count lo=%b: got %0d expected %0d", lo, strb_q.size(), nb);
      else passed++;
      for (int i = 0; i < nb && i < strb_q.size(); i++) begin
        ebs = (lo || i == 1) ? 1'b1 : 1'b0;
        ed  = ebs ? d[7:0] : d[15:8];
        checks++;
        if (strb_q[i].len != T || strb_q[i].bs !== ebs || strb_q[i].data !== ed || strb_q[i].rnum !== r ||
            strb_q[i].rnw !== 1'b0 || !strb_q[i].stable || strb_q[i].start != acc + S + 1 + i * B)
          $display("FAIL wr_strobe%0d: got len=%0d bs=%b data=%h reg=%h rnw=%b stable=%b start=%0d expected len=%0d bs=%b data=%h reg=%h rnw=0 stable=1 start=%0d",
                   i, strb_q[i].len, strb_q[i].bs, strb_q[i].data, strb_q[i].rnum, strb_q[i].rnw,
                   strb_q[i].stable, strb_q[i].start, T, ebs, ed, r, acc + S + 1 + i * B);
        else passed++;
      end
      checks++;
      if (rsp_cyc_q.size() != 0) $display("FAIL wr_no_rsp: got %0d pulses expected 0", rsp_cyc_q.size());
      else passed++;
    end
  endtask

`ifdef XOSERA_BUS_READ_EN
  task automatic test_read();
    logic [3:0]  r;
    logic        lo;
    logic [15:0] exp_w;
    int acc, lat, nb;
    for (int p = 0; p < 4; p++) begin
      r  = (p == 0) ? 4'h2 : 4'($urandom_range(15));
      lo = (p == 1) ? 1'b1 : ((p == 0) ? 1'b0 : 1'($urandom_range(1)));
      rd_hi_v = (p == 0) ? 8'h12 : 8'($urandom);
      rd_lo_v = (p == 0) ? 8'h34 : 8'($urandom);
      exp_w = lo ? {8'h00, rd_lo_v} : {rd_hi_v, rd_lo_v};
      nb = lo ? 1 : 2;
      clear_logs();
      do_cmd(1'b1, lo, r, 16'($urandom), acc, lat);
      repeat (3) @(negedge clk);
      checks++;
      if (lat != nb * B + 1) $display("FAIL rd_latency: got %0d expected %0d", lat, nb * B + 1);
      else passed++;
      checks++;
      if (strb_q.size() != nb) $display("FAIL rd_strobe_count: got %0d expected %0d", strb_q.size(), nb);
      else passed++;
      for (int i = 0; i < nb && i < strb_q.size(); i++) begin
        checks++;
        if (strb_q[i].rnw !== 1'b1 || strb_q[i].len != T || strb_q[i].rnum !== r ||
            strb_q[i].bs !== ((lo || i == 1) ? 1'b1 : 1'b0))
          $display("FAIL rd_strobe%0d: got rnw=%b len=%0d reg=%h bs=%b expected rnw=1 len=%0d reg=%h",
                   i, strb_q[i].rnw, strb_q[i].len, strb_q[i].rnum, strb_q[i].bs, T, r);
        else passed++;
      end
      checks++;
      if (rsp_cyc_q.size() != 1) $display("FAIL rd_rsp_count: got %0d expected 1", rsp_cyc_q.size());
      else passed++;
      if (rsp_cyc_q.size() == 1) begin
        checks++;
        if (rsp_cyc_q[0] != acc + lat || rsp_dat_q[0] !== exp_w)
          $display("FAIL rd_rsp: got cycle=%0d data=%h expected cycle=%0d data=%h",
                   rsp_cyc_q[0], rsp_dat_q[0], acc + lat, exp_w);
        else passed++;
      end
      checks++;
      if (rsp_data !== exp_w || rsp_valid !== 1'b0 || xosera_rd_nwr !== 1'b1)
        $display("FAIL rd_hold: got data=%h rv=%b rnw=%b expected data=%h rv=0 rnw=1",
                 rsp_data, rsp_valid, xosera_rd_nwr, exp_w);
      else passed++;
    end
  endtask
`else
  task automatic test_null_read();
    int acc, lat;
    for (int p = 0; p < 3; p++) begin
      clear_logs();
      do_cmd(1'b1, 1'($urandom_range(1)), 4'($urandom_range(15)), 16'($urandom), acc, lat);
      repeat (3) @(negedge clk);
      checks++;
      if (lat != 1) $display("FAIL nullrd_latency: got %0d expected 1", lat);
      else passed++;
      checks++;
      if (strb_q.size() != 0) $display("FAIL nullrd_no_strobe: got %0d expected 0", strb_q.size());
      else passed++;
      checks++;
      if (rsp_cyc_q.size() != 1) $display("FAIL nullrd_rsp_count: got %0d expected 1", rsp_cyc_q.size());
      else passed++;
      if (rsp_cyc_q.size() == 1) begin
        checks++;
        if (rsp_cyc_q[0] != acc + 1 || rsp_dat_q[0] !== 16'h0000)
          $display("FAIL nullrd_rsp: got cycle=%0d data=%h expected cycle=%0d data=0000",
                   rsp_cyc_q[0], rsp_dat_q[0], acc + 1);
        else passed++;
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [15:0] d1, d2;
    logic [7:0]  ed [4];
    int acc1, acc2, n, min_gap;
    d1 = 16'($urandom);
    d2 = 16'($urandom);
    ed[0] = d1[15:8]; ed[1] = d1[7:0]; ed[2] = d2[15:8]; ed[3] = d2[7:0];
    clear_logs();
    cmd_rd = 1'b0; cmd_lo_only = 1'b0; cmd_reg = 4'h5; cmd_data = d1; cmd_valid = 1'b1;
    @(negedge clk);
    acc1 = cyc - 1;
    cmd_reg = 4'h6; cmd_data = d2;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    acc2 = cyc - 1;
    cmd_valid = 1'b0;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (acc2 - acc1 != 2 * B + 1) $display("FAIL b2b_accept: got %0d expected %0d", acc2 - acc1, 2 * B + 1);
    else passed++;
    checks++;
    if (strb_q.size() != 4) $display("FAIL b2b_strobe_count: got %0d expected 4", strb_q.size());
    else passed++;
    min_gap = 1000;
    for (int i = 0; i < 4 && i < strb_q.size(); i++) begin
      if (i > 0 && strb_q[i].start - (strb_q[i-1].start + strb_q[i-1].len) < min_gap)
        min_gap = strb_q[i].start - (strb_q[i-1].start + strb_q[i-1].len);
      checks++;
      if (strb_q[i].data !== ed[i] || strb_q[i].rnum !== ((i < 2) ? 4'h5 : 4'h6) ||
          strb_q[i].start != ((i < 2) ? acc1 : acc2) + S + 1 + (i % 2) * B)
        $display("FAIL b2b_strobe%0d: got data=%h reg=%h start=%0d expected data=%h start=%0d", i,
                 strb_q[i].data, strb_q[i].rnum, strb_q[i].start, ed[i],
                 ((i < 2) ? acc1 : acc2) + S + 1 + (i % 2) * B);
      else passed++;
    end
    checks++;
    if (min_gap < H + S) $display("FAIL b2b_gap: got %0d expected >= %0d", min_gap, H + S);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n, acc, lat;
    logic rd;
`ifdef XOSERA_BUS_READ_EN
    rd = 1'b1;
`else
    rd = 1'b0;
`endif
    rd_hi_v = 8'hC3; rd_lo_v = 8'h3C;
    cmd_rd = rd; cmd_lo_only = 1'b0; cmd_reg = 4'h9; cmd_data = 16'hBEEF; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!(xosera_cs_n === 1'b0 && xosera_bytesel === 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) $display("FAIL rst_mid_reach: got timeout expected second-byte strobe");
    else passed++;
    clear_logs();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, rsp_valid, rsp_data, xosera_cs_n, xosera_rd_nwr, xosera_reg_num,
         xosera_bytesel, xosera_data_out} !== {1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, IDLE_RNW, 4'h0, 1'b0, 8'h00})
      $display("FAIL rst_mid_values: got rdy=%b busy=%b rv=%b rd=%h cs=%b rnw=%b reg=%h bs=%b do=%h",
               cmd_ready, busy, rsp_valid, rsp_data, xosera_cs_n, xosera_rd_nwr, xosera_reg_num,
               xosera_bytesel, xosera_data_out);
    else passed++;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (rsp_cyc_q.size() != 0 || busy !== 1'b0)
      $display("FAIL rst_mid_dropped: got %0d pulses busy=%b expected 0 pulses busy=0", rsp_cyc_q.size(), busy);
    else passed++;
    clear_logs();
    do_cmd(1'b0, 1'b0, 4'h7, 16'h1357, acc, lat);
    @(negedge clk);
    checks++;
    if (lat != 2 * B + 1 || strb_q.size() != 2) $display("FAIL rst_mid_next: got lat=%0d strobes=%0d expected lat=%0d strobes=2",
                                                         lat, strb_q.size(), 2 * B + 1);
    else passed++;
    if (strb_q.size() == 2) begin
      checks++;
      if (strb_q[0].data !== 8'h13 || strb_q[1].data !== 8'h57)
        $display("FAIL rst_mid_next_data: got %h %h expected 13 57", strb_q[0].data, strb_q[1].data);
      else passed++;
    end
  endtask

  initial begin
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_write(1'b0, 4);
    test_write(1'b1, 3);
`ifdef XOSERA_BUS_READ_EN
    test_read();
`else
    test_null_read();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/xosera_bus_master.md
Name: xosera_bus_master

Overview:
- Upstream driver of the Xosera 8-bit register bus.
- Accepts 16-bit register read/write commands on a valid/ready interface. Serialises each command into one or two timed byte cycles on the cs_n/rd_nwr/reg_num/bytesel/data pins feeding xosera_main.
- Reads return a 16-bit response word.
- Sits between the system command source (test sequencer or CPU bridge) and the Xosera bus inputs in top, in the clk_pix domain.

Parameters:
- SETUP_CYCLES, 1: cycles address/data/bytesel are driven before cs_n falls; legal range ≥1.
- STROBE_CYCLES, 4: cycles cs_n is held low; legal range ≥2.
- HOLD_CYCLES, 2: cycles signals are held after cs_n rises; legal range ≥1.

Ports:
- clk  in  1  pixel clock; only clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_rd  in  1  1 = read, 0 = write.
- cmd_lo_only  in  1  transfer only the low byte (bytesel=1 cycle).
- cmd_reg  in  4  Xosera register number.
- cmd_data  in  16  write data.
- rsp_valid  out  1  one-cycle pulse; read data valid.
- rsp_data  out  16  read result; held until next read completes.
- busy  out  1  high whenever state != IDLE.
- xosera_cs_n  out  1  bus chip select, active low.
- xosera_rd_nwr  out  1  bus direction.
- xosera_reg_num  out  4  bus register number.
- xosera_bytesel  out  1  0 = high byte, 1 = low byte.
- xosera_data_out  out  8  bus write data.
- xosera_data_in  in  8  bus read data from Xosera.

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0.
  - xosera_cs_n=1, xosera_rd_nwr=1, xosera_reg_num=0, xosera_bytesel=0, xosera_data_out=0.
- All bus outputs are registered; no combinational path from cmd_* to bus pins.
- Accept: when cmd_valid && cmd_ready, latch cmd_*; SETUP begins the next cycle.
- States:
  - IDLE → SETUP on accept.
  - SETUP (cs_n=1, lines driven) → STROBE after SETUP_CYCLES.
  - STROBE (cs_n=0) → HOLD after STROBE_CYCLES.
  - HOLD (cs_n=1, lines held) → second-byte SETUP if a byte remains; otherwise IDLE.
- Byte order:
  - Full word: high byte first (bytesel=0, data=cmd_data[15:8]), then low byte (bytesel=1, data=cmd_data[7:0]).
  - cmd_lo_only: single low-byte cycle.
- Read sampling: on the last STROBE cycle, sample xosera_data_in into the current byte. For a lo_only read, high byte = 0.
- Read completion: rsp_valid pulses in the cycle the FSM re-enters IDLE. No backpressure on the response.
- Timing: one byte cycle = B = SETUP+STROBE+HOLD. Full command occupies 2B cycles from first SETUP cycle to IDLE; cmd_ready returns in the following cycle. Defaults: B=7, full=14.
- Phase counter: single down-counter, width $clog2 of max parameter, reloaded at each phase entry.
- Idle bus: cs_n=1; reg_num/data/bytesel retain last values. rd_nwr returns to 1 in IDLE.
- Back-to-back commands: a command presented while busy waits. It is accepted the cycle cmd_ready=1, giving at least HOLD_CYCLES+SETUP_CYCLES of cs_n high between strobes.
- Reset mid-operation: next edge forces reset values including cs_n=1. The in-flight command is dropped with no rsp_valid.
- Illegal parameters: trigger an elaboration-time $error.

Optional Feature:
- Macro: XOSERA_BUS_READ_EN.
- Defined: reads behave as above.
- Undefined:
  - rd_nwr is tied 0 and the sampling logic is omitted.
  - A read command is accepted and performs no bus cycle.
  - rsp_valid pulses the cycle after accept with rsp_data=16'h0000.

Decomposition:
- Package xosera_bus_pkg:
  - state enum {IDLE, SETUP, STROBE, HOLD};
  - default timing localparams;
  - BYTESEL_HI=1'b0, BYTESEL_LO=1'b1.
- No sub-module: the phase counter and FSM are small enough to stay inline.

Test Plan:
- Write reg 4'h3 data 16'hA55A, defaults:
  - cs_n low twice, 4 cycles each;
  - first strobe bytesel=0 data=8'hA5, second bytesel=1 data=8'h5A;
  - cmd_ready high again 15 cycles after accept.
- Read reg 4'h2, model drives 8'h12 then 8'h34:
  - rd_nwr=1;
  - rsp_valid single pulse with rsp_data=16'h1234 on return to IDLE.
- lo_only write reg 4'h1 data 16'hFF77:
  - exactly one strobe, bytesel=1, data=8'h77;
  - 8 cycles accept-to-ready.
- Back-to-back: cmd_valid held high for two writes:
  - second accepted the first cycle cmd_ready=1;
  - cs_n high ≥3 cycles between strobes;
  - no command lost.
- Reset asserted during second-byte STROBE of a read:
  - cs_n=1 next cycle;
  - all outputs at reset values;
  - no rsp_valid;
  - the next command runs normally.
- Build without XOSERA_BUS_READ_EN, issue read:
  - no cs_n activity;
  - rsp_valid one cycle after accept with rsp_data=0.
